// File: rtl/ifetch_queue_if.sv
// ----------------------------------------------------------------------------
// ifetch_queue_if
//   Fetch-to-decode channel of the instruction fetch queue.
//
//   Handshake (valid/ready, i_stall is the inverse of ready):
//     The head entry {o_pc, o_PC_4, o_instruction} is transferred to decode
//     at a rising edge where o_valid=1 and i_stall=0. While o_valid=1 and
//     i_stall=1 the head entry is held unchanged. i_stall has no effect
//     while o_valid=0. A redirect in the same cycle cancels the transfer.
//
//   Signals:
//     o_valid        head entry present (o_count != 0)
//     o_instruction  head instruction word
//     o_pc           head PC
//     o_PC_4         head PC + 4 (mod 2^NBITS)
//     o_halted       halt word enqueued, fetch stopped
//     o_count        queue occupancy
//     i_stall        decode not ready, head entry held
//
//   Modports: master = fetch queue side, slave = decode side.
// ----------------------------------------------------------------------------
interface ifetch_queue_if #(
  parameter int NBITS  = 32,
  parameter int QDEPTH = 4
);
  localparam int CW = $clog2(QDEPTH + 1);

  logic             o_valid;
  logic [NBITS-1:0] o_instruction;
  logic [NBITS-1:0] o_pc;
  logic [NBITS-1:0] o_PC_4;
  logic             o_halted;
  logic [CW-1:0]    o_count;
  logic             i_stall;

  modport master (
    output o_valid, o_instruction, o_pc, o_PC_4, o_halted, o_count,
    input  i_stall
  );

  modport slave (
    input  o_valid, o_instruction, o_pc, o_PC_4, o_halted, o_count,
    output i_stall
  );
endinterface

// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
//   Instruction fetch stage: PC register, synchronous-read instruction memory
//   with a loader write port, and a QDEPTH-entry queue of {pc, pc+4, instr}
//   that decouples fetch from decode.
//
//   Ports:
//     i_clk          clock, all state on rising edge
//     i_reset        synchronous active-high reset, dominates all inputs
//     i_enable       1 = new fetches may be issued
//     i_redirect     one-cycle pulse: flush queue/in-flight read, restart
//     i_redirect_pc  byte address of the redirect target
//     i_load_we      instruction memory write strobe
//     i_load_addr    word address for load
//     i_load_data    word to write
//     dec            decode channel (see ifetch_queue_if for the handshake)
//
//   Pipeline: a read issued in cycle N returns data in N+1, is enqueued at
//   the end of N+1 and is visible at the queue head in N+2. Issue is gated by
//   count + inflight < QDEPTH so the queue can never overflow.
// ----------------------------------------------------------------------------
module ifetch_queue #(
  parameter int               NBITS     = 32,
  parameter int               MEM_WORDS = 256,
  parameter int               QDEPTH    = 4,
  parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [NBITS-1:0] RESET_PC  = '0
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic                         i_redirect,
  input  logic [NBITS-1:0]             i_redirect_pc,
  input  logic                         i_load_we,
  input  logic [$clog2(MEM_WORDS)-1:0] i_load_addr,
  input  logic [NBITS-1:0]             i_load_data,
  ifetch_queue_if.master               dec
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = $clog2(QDEPTH);

  localparam logic [NBITS-1:0] PC_STEP  = NBITS'(4);
  localparam logic [CW:0]      QD_LIMIT = (CW+1)'(QDEPTH);
  localparam logic [PW-1:0]    PTR_LAST = PW'(QDEPTH - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [NBITS-1:0] r_mem [MEM_WORDS];

  logic [NBITS-1:0] r_pc;          // next fetch address
  logic [NBITS-1:0] r_fetch_pc;    // address of the read currently in flight
  logic [NBITS-1:0] r_rdata;       // memory read register
  logic             r_inflight;    // r_rdata holds a response to enqueue
  logic             r_halted;

  logic [NBITS-1:0] r_q_pc   [QDEPTH];
  logic [NBITS-1:0] r_q_pc4  [QDEPTH];
  logic [NBITS-1:0] r_q_ins  [QDEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  // --------------------------------------------------------------------------
  // Control
  // --------------------------------------------------------------------------
  logic [AW-1:0] w_rd_idx;
  logic [CW:0]   w_occupancy;
  logic          w_issue;
  logic          w_enq;
  logic          w_pop;
  logic          w_halt_hit;
  logic          w_valid;

  // Low two PC bits are a byte offset and play no part in addressing.
  assign w_rd_idx = r_pc[AW+1:2];

  // Reserved slots include the read in flight so its response always fits.
  assign w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};

  assign w_valid = (r_count != '0);

  assign w_issue = !i_reset && i_enable && !r_halted && !i_redirect &&
                   (w_occupancy < QD_LIMIT);

  // Redirect cancels the response, the pop and halt detection this cycle.
  assign w_enq      = !i_reset && !i_redirect && r_inflight;
  assign w_pop      = !i_reset && !i_redirect && w_valid && !dec.i_stall;
  assign w_halt_hit = w_enq && (r_rdata == HALT_WORD);

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // --------------------------------------------------------------------------
  // Instruction memory: loader write, synchronous read on issue. Reading and
  // writing the same word in one cycle returns the old contents.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_load_we) begin
      r_mem[i_load_addr] <= i_load_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_issue) begin
      r_rdata <= r_mem[w_rd_idx];
    end
  end

  // --------------------------------------------------------------------------
  // Queue storage (contents only; occupancy is tracked below)
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_q_pc[r_wr_ptr]  <= r_fetch_pc;
      r_q_pc4[r_wr_ptr] <= r_fetch_pc + PC_STEP;
      r_q_ins[r_wr_ptr] <= r_rdata;
    end
  end

  // --------------------------------------------------------------------------
  // PC, in-flight tracking, halt and queue pointers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc       <= RESET_PC;
      r_fetch_pc <= '0;
      r_inflight <= 1'b0;
      r_halted   <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (i_redirect) begin
      r_pc       <= i_redirect_pc;
      r_inflight <= 1'b0;
      r_halted   <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_issue) begin
        r_pc       <= r_pc + PC_STEP;
        r_fetch_pc <= r_pc;
      end

      // A read issued alongside the halt response is dropped: its data
      // would belong to the instruction after the halt word.
      r_inflight <= w_issue && !w_halt_hit;

      if (w_halt_hit) begin
        r_halted <= 1'b1;
      end

      if (w_enq) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end

      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: head entry, forced to zero while the queue is empty so that
  // stale storage never shows on the bus.
  // --------------------------------------------------------------------------
  assign dec.o_valid       = w_valid;
  assign dec.o_instruction = w_valid ? r_q_ins[r_rd_ptr] : '0;
  assign dec.o_pc          = w_valid ? r_q_pc[r_rd_ptr]  : '0;
  assign dec.o_PC_4        = w_valid ? r_q_pc4[r_rd_ptr] : '0;
  assign dec.o_halted      = r_halted;
  assign dec.o_count       = r_count;

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
  localparam int          NB   = 32;
  localparam int          MW   = 256;
  localparam int          QD   = 4;
  localparam int          W    = 3 * NB;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        redir;
  logic [31:0] redir_pc;
  logic        load_we;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        mon_on;

  always #5 clk = ~clk;

  ifetch_queue_if #(.NBITS(NB), .QDEPTH(QD)) dec_if ();

  ifetch_queue #(
    .NBITS(NB), .MEM_WORDS(MW), .QDEPTH(QD), .HALT_WORD(HALT), .RESET_PC(32'h0)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_enable(en),
    .i_redirect(redir),
    .i_redirect_pc(redir_pc),
    .i_load_we(load_we),
    .i_load_addr(load_addr),
    .i_load_data(load_data),
    .dec(dec_if)
  );

  // ---------------- reference model + scoreboard ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] tb_mem [MW];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Program-order stream from 'start': sequential words, ending with (and
  // including) the first halt word. This is what decode must receive.
  task automatic start_stream(input logic [31:0] start);
    logic [31:0] p;
    logic [31:0] w;
    exp_q.delete();
    p = start;
    for (int n = 0; n < 400; n++) begin
      w = tb_mem[p[9:2]];
      exp_q.push_back({p, p + 32'd4, w});
      if (w == HALT) break;
      p = p + 32'd4;
    end
  endtask

  // Monitor: every accepted head entry is compared with the stream front.
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      check32("valid_vs_count", 32'(dec_if.o_valid), 32'(dec_if.o_count != 0));
      check32("count_bound", 32'(dec_if.o_count <= QD), 32'd1);
      if (dec_if.o_valid && !dec_if.i_stall && !redir) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_delivery: got pc %h expected none (t=%0t)", dec_if.o_pc, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check32("deliver_pc", dec_if.o_pc, mon_e[95:64]);
          check32("deliver_pc4", dec_if.o_PC_4, mon_e[63:32]);
          check32("deliver_ins", dec_if.o_instruction, mon_e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int a, input logic [31:0] d);
    load_we   = 1'b1;
    load_addr = 8'(a);
    load_data = d;
    tb_mem[a] = d;
    tick();
    load_we   = 1'b0;
  endtask

  task automatic wait_count(input int n, input string name);
    int k;
    k = 0;
    while (int'(dec_if.o_count) != n && k < 40) begin
      tick();
      k++;
    end
    check32(name, 32'(dec_if.o_count), 32'(n));
  endtask

  task automatic check_zero_outputs(input string tag);
    check32({tag, "_valid"}, 32'(dec_if.o_valid), 32'd0);
    check32({tag, "_count"}, 32'(dec_if.o_count), 32'd0);
    check32({tag, "_pc"}, dec_if.o_pc, 32'd0);
    check32({tag, "_pc4"}, dec_if.o_PC_4, 32'd0);
    check32({tag, "_ins"}, dec_if.o_instruction, 32'd0);
    check32({tag, "_halted"}, 32'(dec_if.o_halted), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    logic [31:0] rp;
    int          r;
    int          k;

    rst = 1'b1; en = 1'b0; redir = 1'b0; redir_pc = '0;
    load_we = 1'b0; load_addr = '0; load_data = '0;
    dec_if.i_stall = 1'b0;
    mon_on = 1'b1;
    repeat (3) tick();
    check_zero_outputs("reset");

    // Load program with fetch disabled.
    rst = 1'b0;
    for (int i = 0; i < MW; i++) begin
      d = (i < 8) ? (32'h1000_0000 + 32'(i)) : $urandom();
      if (d == HALT) d = 32'h0;
      load_word(i, d);
    end

    // Streaming from reset: visible two cycles after first enabled cycle.
    start_stream(32'h0);
    en = 1'b1;
    tick();
    tick();
    check32("first_valid", 32'(dec_if.o_valid), 32'd1);
    check32("first_pc", dec_if.o_pc, 32'h0);
    check32("first_pc4", dec_if.o_PC_4, 32'h4);
    check32("first_ins", dec_if.o_instruction, 32'h1000_0000);
    // pc=8 is being read this cycle; overwrite word 2 now (read sees old).
    load_we = 1'b1; load_addr = 8'd2; load_data = 32'hABCD_0002;
    tb_mem[2] = 32'hABCD_0002;
    for (int i = 1; i < 8; i++) begin
      tick();
      load_we = 1'b0;
      check32("stream_valid", 32'(dec_if.o_valid), 32'd1);
      check32("stream_pc", dec_if.o_pc, 32'(4 * i));
    end

    // Stall saturation after redirect to 0 (word 2 now holds the new value).
    dec_if.i_stall = 1'b1;
    redir = 1'b1; redir_pc = 32'h0;
    start_stream(32'h0);
    tick();
    redir = 1'b0;
    repeat (10) tick();
    check32("stall_count", 32'(dec_if.o_count), 32'd4);
    check32("stall_head_pc", dec_if.o_pc, 32'h0);
    check32("stall_head_ins", dec_if.o_instruction, 32'h1000_0000);
    dec_if.i_stall = 1'b0;
    repeat (8) tick();

    // Redirect with 3 entries queued.
    dec_if.i_stall = 1'b1;
    wait_count(3, "fill_to_3");
    redir = 1'b1; redir_pc = 32'h20; dec_if.i_stall = 1'b0;
    start_stream(32'h20);
    tick();
    redir = 1'b0;
    check32("redir_count", 32'(dec_if.o_count), 32'd0);
    check32("redir_valid_n1", 32'(dec_if.o_valid), 32'd0);
    tick();
    check32("redir_valid_n2", 32'(dec_if.o_valid), 32'd0);
    tick();
    check32("redir_valid_n3", 32'(dec_if.o_valid), 32'd1);
    check32("redir_pc", dec_if.o_pc, 32'h20);
    check32("redir_ins", dec_if.o_instruction, tb_mem[8]);

    // Halt word at word 5.
    en = 1'b0;
    repeat (4) tick();
    load_word(5, HALT);
    redir = 1'b1; redir_pc = 32'h0;
    start_stream(32'h0);
    tick();
    redir = 1'b0; en = 1'b1;
    k = 0;
    while (!dec_if.o_halted && k < 30) begin
      tick();
      k++;
    end
    check32("halt_seen", 32'(dec_if.o_halted), 32'd1);
    check32("halt_head_pc", dec_if.o_pc, 32'h14);
    check32("halt_head_ins", dec_if.o_instruction, HALT);
    repeat (6) tick();
    check32("halt_drained", 32'(exp_q.size()), 32'd0);
    check32("halt_idle_valid", 32'(dec_if.o_valid), 32'd0);
    check32("halt_sticky", 32'(dec_if.o_halted), 32'd1);
    redir = 1'b1; redir_pc = 32'h18;
    start_stream(32'h18);
    tick();
    redir = 1'b0;
    check32("halt_cleared", 32'(dec_if.o_halted), 32'd0);
    tick();
    tick();
    check32("restart_valid", 32'(dec_if.o_valid), 32'd1);
    check32("restart_pc", dec_if.o_pc, 32'h18);

    // Reset with a full queue.
    dec_if.i_stall = 1'b1;
    wait_count(4, "fill_to_4");
    rst = 1'b1;
    start_stream(32'h0);
    tick();
    check_zero_outputs("midreset");
    rst = 1'b0; dec_if.i_stall = 1'b0;
    tick();
    tick();
    check32("post_reset_valid", 32'(dec_if.o_valid), 32'd1);
    check32("post_reset_pc", dec_if.o_pc, 32'h0);

    // Random phase: scatter halt words, then random stall/enable/redirect/reset.
    en = 1'b0;
    repeat (4) tick();
    for (int j = 0; j < 6; j++) load_word($urandom_range(8, MW - 1), HALT);
    redir = 1'b1; redir_pc = 32'h0;
    start_stream(32'h0);
    tick();
    redir = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 999);
      rst = 1'b0;
      redir = 1'b0;
      if (r < 5) begin
        rst = 1'b1;
        start_stream(32'h0);
      end else if (r < 40) begin
        rp = $urandom();
        if (r < 12) rp = 32'hFFFF_FFF0 | (rp & 32'hC);
        else if (r >= 15) rp = rp & 32'hFFFF_FFFC;
        redir = 1'b1; redir_pc = rp;
        start_stream(rp);
      end
      dec_if.i_stall = ($urandom_range(0, 99) < 30);
      en = ($urandom_range(0, 99) < 90);
      tick();
    end
    rst = 1'b0; redir = 1'b0; dec_if.i_stall = 1'b0; en = 1'b1;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Parametrised successor fetch stage: PC register, synchronous-read instruction memory with a load port, and a QDEPTH-entry fetch queue that decouples fetch from decode.
- Supports branch/jump redirect with flush of the queue and in-flight read, halt-word detection, a decode-side stall, and a global enable.
- Sits between the program loader/debug unit and the decode stage; each queue entry carries {pc, pc+4, instruction}.

Parameters:
NBITS, 32, datapath width of PC and instruction
MEM_WORDS, 256, instruction memory depth in words (power of 2)
QDEPTH, 4, fetch queue entries (≥2; ≥3 for 1 instr/cycle sustained)
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch
RESET_PC, 0, PC value after reset

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset  in  1  synchronous, active-high reset; dominates every other input
i_enable  in  1  1 = new fetches may be issued; 0 = no new issue (in-flight read still completes, queue still pops)
i_stall  in  1  decode not ready; head entry held
i_redirect  in  1  one-cycle pulse: flush and restart fetch at i_redirect_pc
i_redirect_pc  in  NBITS  byte address of redirect target
i_load_we  in  1  instruction memory write strobe
i_load_addr  in  $clog2(MEM_WORDS)  word address for load
i_load_data  in  NBITS  word to write
o_valid  out  1  queue head valid (count != 0)
o_instruction  out  NBITS  head instruction
o_pc  out  NBITS  head PC
o_PC_4  out  NBITS  head PC + 4 (mod 2^NBITS)
o_halted  out  1  halt word has been enqueued; fetch stopped
o_count  out  $clog2(QDEPTH+1)  current queue occupancy

Behaviour:
- Reset: PC=RESET_PC, queue empty, in-flight flag/discard cleared, halted=0; o_valid=0, o_instruction=0, o_pc=0, o_PC_4=0, o_halted=0, o_count=0. Memory contents are not reset.
- Memory addressing: word index = PC[$clog2(MEM_WORDS)+1:2], wrapping modulo MEM_WORDS. PC low 2 bits are ignored for addressing.
- Memory read latency: address in cycle N, data registered at end of N, available in N+1.
- Issue rule (cycle N): issue iff i_enable && !halted && !i_redirect && (count + inflight) < QDEPTH.
  - On issue: read at PC, PC <= PC+4 (wraps mod 2^NBITS), inflight set for N+1.
- Response (cycle N+1): if not discarded, enqueue {pc, pc+4, data} at end of N+1. Entry is visible on outputs in N+2.
- Sustained throughput: one instruction per cycle when QDEPTH ≥ 3 and no stall.
- Pop: o_valid && !i_stall removes the head at the edge. Enqueue and pop in the same cycle leave count unchanged. A full queue never overflows, by the issue rule.
- Halt:
  - When the response data == HALT_WORD, it is enqueued normally and halted <= 1.
  - Any read issued in the same cycle as that response is discarded; no further issue.
  - o_halted is high from the cycle after the halt word is enqueued. The halt entry is still delivered to decode.
- Redirect (cycle N):
  - Queue flushed and any in-flight response discarded.
  - halted cleared; PC <= i_redirect_pc; no issue in N.
  - Target read issued in N+1; target entry visible with o_valid=1 in N+3.
  - Redirect beats pop, enqueue and halt detection in the same cycle.
- Reset mid-operation: same as the reset values above. First issue is in the first cycle with i_reset=0 and i_enable=1; that entry is visible two cycles later.
- Load port:
  - Write occurs at the edge when i_load_we=1, independent of i_enable.
  - Read and write to the same word in the same cycle: the read returns the old data.
  - The loader keeps i_enable low while loading; the block does not enforce this.
- i_enable low: the current in-flight read still enqueues; PC is held.

Test Plan:
- Load words 0..7 = 0x1000_0000+i, release reset, enable, no stall -> o_valid from cycle 2, o_pc=0,4,8,... and o_instruction=0x1000_0000,...+1 on consecutive cycles; o_PC_4=o_pc+4.
- Hold i_stall=1 for 10 cycles with QDEPTH=4 -> o_count saturates at 4, head stays pc=0. Release stall -> entries 0,4,8,12,16 delivered in order, no loss or duplicate.
- Pulse i_redirect with pc=0x20 while the queue holds 3 entries -> o_count=0 next cycle, o_valid=0 for two cycles, then o_pc=0x20 with instruction word 8.
- Place HALT_WORD at word 5 -> entries up to pc=0x14 delivered, o_halted=1 after pc=0x14 is enqueued, no pc=0x18 ever appears. A later redirect to 0 clears o_halted and restarts fetch.
- Assert i_reset mid-stream with a full queue -> next cycle all outputs 0, then fetch resumes at RESET_PC.
- Write word 2 via the load port in the same cycle PC=8 is read -> old value returned. A subsequent redirect to 8 returns the new value.
